dram_dqs_wr_seq: RTL and testbench

Write-strobe sequencer directly upstream of the DQS pad slice. Converts a single-cycle write-burst request from the DRAM channel controller into the cycle-accurate DQS drive pattern (latency wait, preamble, toggling burst, postamble) on `dram_io_drive_enable` / `dram_io_drive_data`, which feed the pad's edge logic. A one-entry pending slot lets a request issued during an active burst follow immediately after the current postamble.

---
 rtl/dram_dqs_wr_pkg.sv | 17 +
 rtl/dram_dqs_wr_pend.sv | 63 ++++++
 rtl/dram_dqs_wr_seq.sv | 156 +++++++++++++++
 tb/tb_dram_dqs_wr_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_dqs_wr_pkg.sv
// Shared types and constants for the DQS write-strobe sequencer.
package dram_dqs_wr_pkg;

    localparam int DQS_LAT_W_DEFAULT = 4;

    localparam logic [2:0] BL4_LAST = 3'd3;
    localparam logic [2:0] BL8_LAST = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PRE   = 3'd2,
        ST_BURST = 3'd3,
        ST_POST  = 3'd4
    } dqs_state_e;

endpackage

// File: rtl/dram_dqs_wr_pend.sv
// One-entry pending request slot. A request arriving in the same cycle the
// slot is consumed is bypassed straight to the consumer when the slot is empty.
module dram_dqs_wr_pend #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             capture,
    input  logic             consume,
    input  logic [LAT_W-1:0] in_lat,
    input  logic             in_bl8,
    output logic             take_valid,
    output logic [LAT_W-1:0] take_lat,
    output logic             take_bl8,
    output logic             overrun
);

    logic             valid_r;
    logic [LAT_W-1:0] lat_r;
    logic             bl8_r;
    logic             overrun_r;

    // Held entry wins; otherwise the incoming request is offered directly.
    always_comb begin
        take_valid = valid_r | capture;
        take_lat   = valid_r ? lat_r : in_lat;
        take_bl8   = valid_r ? bl8_r : in_bl8;
    end

    // Slot storage and drop detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= 1'b0;
            lat_r     <= {LAT_W{1'b0}};
            bl8_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= capture & valid_r & ~consume & ~clear;
            if (clear) begin
                valid_r <= 1'b0;
            end else if (consume) begin
                // Held entry leaves; a simultaneous new request refills the slot.
                if (valid_r && capture) begin
                    valid_r <= 1'b1;
                    lat_r   <= in_lat;
                    bl8_r   <= in_bl8;
                end else begin
                    valid_r <= 1'b0;
                end
            end else if (capture && !valid_r) begin
                valid_r <= 1'b1;
                lat_r   <= in_lat;
                bl8_r   <= in_bl8;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign overrun = overrun_r;

endmodule

// File: rtl/dram_dqs_wr_seq.sv
// DQS write-strobe sequencer: latency wait, preamble, toggling burst and
// postamble, with a one-entry pending slot for chained bursts.
module dram_dqs_wr_seq
    import dram_dqs_wr_pkg::*;
#(
    parameter int LAT_W = DQS_LAT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_start,
    input  logic [LAT_W-1:0] wr_lat,
    input  logic             wr_bl8,
    input  logic             dram_io_channel_disabled,
    output logic             dram_io_drive_enable,
    output logic             dram_io_drive_data,
    output logic             wr_busy,
    output logic             wr_done,
    output logic             wr_overrun
);

    dqs_state_e       state_r, state_nxt_s;
    logic [LAT_W-1:0] lat_cnt_r, lat_nxt_s;
    logic [2:0]       beat_cnt_r, beat_nxt_s;
    logic             bl8_r, bl8_nxt_s;
    logic [2:0]       last_beat_s;

    logic             capture_s, consume_s, clear_s;
    logic             take_valid_s, take_bl8_s;
    logic [LAT_W-1:0] take_lat_s;

    logic             enable_r, data_r, busy_r, done_r;

    assign capture_s   = wr_start & (state_r != ST_IDLE) & ~dram_io_channel_disabled;
    assign last_beat_s = bl8_r ? BL8_LAST : BL4_LAST;

    dram_dqs_wr_pend #(.LAT_W(LAT_W)) u_pend (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_s),
        .capture    (capture_s),
        .consume    (consume_s),
        .in_lat     (wr_lat),
        .in_bl8     (wr_bl8),
        .take_valid (take_valid_s),
        .take_lat   (take_lat_s),
        .take_bl8   (take_bl8_s),
        .overrun    (wr_overrun)
    );

    // Next-state, counter and slot-control decode.
    always_comb begin
        state_nxt_s = state_r;
        lat_nxt_s   = lat_cnt_r;
        beat_nxt_s  = beat_cnt_r;
        bl8_nxt_s   = bl8_r;
        consume_s   = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_start && !dram_io_channel_disabled) begin
                    bl8_nxt_s   = wr_bl8;
                    lat_nxt_s   = wr_lat;
                    state_nxt_s = (wr_lat == {LAT_W{1'b0}}) ? ST_PRE : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dram_io_channel_disabled) begin
                    state_nxt_s = ST_IDLE;
                    clear_s     = 1'b1;
                end else begin
                    // Leaving on a count of one makes WAIT last exactly lat cycles.
                    if (lat_cnt_r <= LAT_W'(1)) begin
                        state_nxt_s = ST_PRE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                    if (lat_cnt_r != {LAT_W{1'b0}}) begin
                        lat_nxt_s = lat_cnt_r - LAT_W'(1);
                    end else begin
                        lat_nxt_s = {LAT_W{1'b0}};
                    end
                end
            end
            ST_PRE: begin
                if (dram_io_channel_disabled) begin
                    state_nxt_s = ST_IDLE;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_BURST;
                    beat_nxt_s  = 3'd0;
                end
            end
            ST_BURST: begin
                if (dram_io_channel_disabled) begin
                    state_nxt_s = ST_IDLE;
                    clear_s     = 1'b1;
                end else if (beat_cnt_r == last_beat_s) begin
                    state_nxt_s = ST_POST;
                end else begin
                    beat_nxt_s = beat_cnt_r + 3'd1;
                end
            end
            ST_POST: begin
                if (dram_io_channel_disabled) begin
                    state_nxt_s = ST_IDLE;
                    clear_s     = 1'b1;
                end else if (take_valid_s) begin
                    consume_s   = 1'b1;
                    bl8_nxt_s   = take_bl8_s;
                    lat_nxt_s   = take_lat_s;
                    state_nxt_s = (take_lat_s == {LAT_W{1'b0}}) ? ST_PRE : ST_WAIT;
                end else begin
                    consume_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                clear_s     = 1'b1;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they line up with the state they describe while still coming from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            lat_cnt_r  <= {LAT_W{1'b0}};
            beat_cnt_r <= 3'd0;
            bl8_r      <= 1'b0;
            enable_r   <= 1'b0;
            data_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lat_cnt_r  <= lat_nxt_s;
            beat_cnt_r <= beat_nxt_s;
            bl8_r      <= bl8_nxt_s;
            enable_r   <= (state_nxt_s == ST_PRE) || (state_nxt_s == ST_BURST) ||
                          (state_nxt_s == ST_POST);
            data_r     <= (state_nxt_s == ST_BURST) && !beat_nxt_s[0];
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_POST);
        end
    end

    assign dram_io_drive_enable = enable_r;
    assign dram_io_drive_data   = data_r;
    assign wr_busy              = busy_r;
    assign wr_done              = done_r;

endmodule

// File: tb/tb_dram_dqs_wr_seq.sv
// Scoreboard bench for dram_dqs_wr_seq: the driver queues the expected
// per-cycle output vector, the monitor pops one per falling edge.
module tb_dram_dqs_wr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_start;
    logic [3:0] wr_lat;
    logic       wr_bl8;
    logic       dis;
    logic       en, dat, busy, done, ovr;

    typedef struct packed {
        logic en;
        logic dat;
        logic busy;
        logic done;
        logic ovr;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  cur, got;
    int    n_vec = 0;
    int    n_err = 0;
    string tname = "reset";

    dram_dqs_wr_seq #(.LAT_W(4)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .wr_start                 (wr_start),
        .wr_lat                   (wr_lat),
        .wr_bl8                   (wr_bl8),
        .dram_io_channel_disabled (dis),
        .dram_io_drive_enable     (en),
        .dram_io_drive_data       (dat),
        .wr_busy                  (busy),
        .wr_done                  (done),
        .wr_overrun               (ovr)
    );

    always #5 clk = ~clk;

    // Monitor: one expected vector per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur   = exp_q.pop_front();
            got   = '{en, dat, busy, done, ovr};
            n_vec = n_vec + 1;
            if (got !== cur) begin
                n_err = n_err + 1;
                $display("FAIL %s t=%0t got en/dat/busy/done/ovr=%b required=%b",
                         tname, $time, got, cur);
            end
        end
    end

    function automatic exp_t ev(input logic e, input logic d, input logic b,
                                input logic dn, input logic o);
        exp_t r;
        r = '{e, d, b, dn, o};
        return r;
    endfunction

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Cycles T+1 onward for one request: WAIT x lat, PRE, beats, POST.
    task automatic push_burst(input int lat, input logic bl8, input int ovr_at);
        int k;
        k = 0;
        for (int i = 0; i < lat; i++) begin
            k++;
            exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, k == ovr_at));
        end
        k++;
        exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 1'b0, k == ovr_at));
        for (int b = 0; b < (bl8 ? 8 : 4); b++) begin
            k++;
            exp_q.push_back(ev(1'b1, (b % 2) == 0, 1'b1, 1'b0, k == ovr_at));
        end
        k++;
        exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 1'b1, k == ovr_at));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input int lat, input logic bl8);
        wr_start = 1'b1;
        wr_lat   = 4'(lat);
        wr_bl8   = bl8;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            $display("FAIL drain_timeout %s pending=%0d required=0", tname, exp_q.size());
            $fatal(1);
        end
        #1;
    endtask

    task automatic single_burst(input string nm);
        tname = nm;
        req(2, 1'b0);
        push_idle(1);
        push_burst(2, 1'b0, -1);
        push_idle(2);
        step(1);
        wr_start = 1'b0;
        drain();
    endtask

    initial begin
        rst      = 1'b1;
        wr_start = 1'b0;
        wr_lat   = 4'd0;
        wr_bl8   = 1'b0;
        dis      = 1'b0;
        step(1);
        push_idle(2);
        step(2);
        rst = 1'b0;
        push_idle(2);
        drain();

        single_burst("single_lat2_bl4");

        tname = "lat0_bl8";
        req(0, 1'b1);
        push_idle(1);
        push_burst(0, 1'b1, -1);
        push_idle(2);
        step(1);
        wr_start = 1'b0;
        drain();

        tname = "chain";
        req(2, 1'b0);
        push_idle(1);
        push_burst(2, 1'b0, -1);
        push_burst(1, 1'b1, -1);
        push_idle(2);
        step(1);
        wr_start = 1'b0;
        step(4);
        req(1, 1'b1);
        step(1);
        wr_start = 1'b0;
        drain();

        tname = "overrun";
        req(2, 1'b0);
        push_idle(1);
        push_burst(2, 1'b0, 7);
        push_burst(1, 1'b1, -1);
        push_idle(2);
        step(1);
        wr_start = 1'b0;
        step(4);
        req(1, 1'b1);
        step(1);
        req(3, 1'b0);
        step(1);
        wr_start = 1'b0;
        drain();

        tname = "chan_disable";
        req(0, 1'b0);
        push_idle(1);
        exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        push_idle(6);
        step(1);
        wr_start = 1'b0;
        step(1);
        req(1, 1'b1);
        step(1);
        wr_start = 1'b0;
        step(1);
        dis = 1'b1;
        step(2);
        req(2, 1'b0);
        step(1);
        wr_start = 1'b0;
        step(1);
        dis = 1'b0;
        drain();

        tname = "after_disable";
        req(0, 1'b0);
        push_idle(1);
        push_burst(0, 1'b0, -1);
        push_idle(2);
        step(1);
        wr_start = 1'b0;
        drain();

        tname = "async_reset";
        req(1, 1'b0);
        push_idle(1);
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        push_idle(4);
        step(1);
        wr_start = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        drain();

        single_burst("single_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
